// File: rtl/data_memory_responder.sv
// Word memory serving the processor data port: zero-fills itself after reset,
// then serves one read or write per cycle with a fixed read latency.
module data_memory_responder #(
    parameter int ADDR_BITS = 8,
    parameter int LATENCY   = 2
) (
    input  logic                 Clock,
    input  logic                 Reset,
    input  logic [19:0]          Daddress,
    input  logic [19:0]          Dout,
    input  logic                 W,
    input  logic                 LoadEn,
    input  logic [ADDR_BITS-1:0] LoadAddr,
    input  logic [19:0]          LoadData,
    output logic [19:0]          DataIn,
    output logic                 DataValid,
    output logic                 Ready
);

    localparam int DEPTH = 1 << ADDR_BITS;

    if (LATENCY < 1 || LATENCY > 4) begin : g_latency_check
        $error("data_memory_responder: LATENCY must be 1..4");
    end

    typedef enum logic {S_INIT, S_ACTIVE} state_t;

    state_t               state_q, state_d;
    logic [ADDR_BITS-1:0] clr_cnt_q, clr_cnt_d;
    logic                 ready_q, ready_d;
    logic [LATENCY-1:0]   vld_q, vld_d;
    logic [19:0]          data_q [LATENCY];
    logic [19:0]          data_d [LATENCY];

    logic [19:0]          mem [DEPTH];
    logic                 wr_en;
    logic [ADDR_BITS-1:0] wr_addr;
    logic [19:0]          wr_data;
    logic [ADDR_BITS-1:0] rd_addr;
    logic                 rd_issue;

    // Upper address bits alias onto the array and are deliberately dropped.
    logic unused_daddr_hi;
    assign unused_daddr_hi = ^Daddress[19:ADDR_BITS];

    always_comb begin
        state_d   = state_q;
        clr_cnt_d = clr_cnt_q;
        ready_d   = ready_q;
        wr_en     = 1'b0;
        wr_addr   = clr_cnt_q;
        wr_data   = '0;
        rd_addr   = Daddress[ADDR_BITS-1:0];
        rd_issue  = 1'b0;

        case (state_q)
            S_INIT: begin
                wr_en     = 1'b1;
                wr_addr   = clr_cnt_q;
                clr_cnt_d = clr_cnt_q + ADDR_BITS'(1);
                if (&clr_cnt_q) begin
                    state_d = S_ACTIVE;
                    ready_d = 1'b1;
                end
            end
            S_ACTIVE: begin
                rd_issue = !W;
                // The preload port wins a same-cycle collision with a core write.
                if (LoadEn) begin
                    wr_en   = 1'b1;
                    wr_addr = LoadAddr;
                    wr_data = LoadData;
                end else if (W) begin
                    wr_en   = 1'b1;
                    wr_addr = Daddress[ADDR_BITS-1:0];
                    wr_data = Dout;
                end
            end
            default: begin
                state_d = S_INIT;
            end
        endcase

        // Data only advances behind a valid bit, so the last stage holds between results.
        vld_d[0]  = rd_issue;
        data_d[0] = rd_issue ? mem[rd_addr] : data_q[0];
        for (int k = 1; k < LATENCY; k++) begin
            vld_d[k]  = vld_q[k-1];
            data_d[k] = vld_q[k-1] ? data_q[k-1] : data_q[k];
        end
    end

    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            state_q   <= S_INIT;
            clr_cnt_q <= '0;
            ready_q   <= 1'b0;
            vld_q     <= '0;
            for (int k = 0; k < LATENCY; k++) begin
                data_q[k] <= '0;
            end
        end else begin
            state_q   <= state_d;
            clr_cnt_q <= clr_cnt_d;
            ready_q   <= ready_d;
            vld_q     <= vld_d;
            for (int k = 0; k < LATENCY; k++) begin
                data_q[k] <= data_d[k];
            end
        end
    end

    // Read data is captured combinationally before this edge's write lands: read-first.
    always_ff @(posedge Clock) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    assign DataIn    = data_q[LATENCY-1];
    assign DataValid = vld_q[LATENCY-1];
    assign Ready     = ready_q;

endmodule

// File: tb/tb_data_memory_responder.sv
// Bench for data_memory_responder: three latency variants driven in lockstep,
// checked against a word-memory model through per-variant expected queues.
module tb_data_memory_responder;

  logic        Clock = 1'b0;
  logic        Reset = 1'b0;
  logic [19:0] Daddress = '0;
  logic [19:0] Dout = '0;
  logic        W = 1'b0;
  logic        LoadEn = 1'b0;
  logic [3:0]  LoadAddr = '0;
  logic [19:0] LoadData = '0;

  logic [19:0] din1, din2, din4;
  logic        dv1, dv2, dv4;
  logic        rdy1, rdy2, rdy4;

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  logic [19:0] model_mem [16];
  logic        model_active = 1'b0;
  int          init_cnt = 0;

  logic [19:0] exp1_q[$], exp2_q[$], exp4_q[$];
  int          due1_q[$], due2_q[$], due4_q[$];

  data_memory_responder #(.ADDR_BITS(4), .LATENCY(1)) dut_l1 (
    .Clock(Clock), .Reset(Reset), .Daddress(Daddress), .Dout(Dout), .W(W),
    .LoadEn(LoadEn), .LoadAddr(LoadAddr), .LoadData(LoadData),
    .DataIn(din1), .DataValid(dv1), .Ready(rdy1));

  data_memory_responder #(.ADDR_BITS(4), .LATENCY(2)) dut_l2 (
    .Clock(Clock), .Reset(Reset), .Daddress(Daddress), .Dout(Dout), .W(W),
    .LoadEn(LoadEn), .LoadAddr(LoadAddr), .LoadData(LoadData),
    .DataIn(din2), .DataValid(dv2), .Ready(rdy2));

  data_memory_responder #(.ADDR_BITS(4), .LATENCY(4)) dut_l4 (
    .Clock(Clock), .Reset(Reset), .Daddress(Daddress), .Dout(Dout), .W(W),
    .LoadEn(LoadEn), .LoadAddr(LoadAddr), .LoadData(LoadData),
    .DataIn(din4), .DataValid(dv4), .Ready(rdy4));

  // clock / cycle counter
  always #5 Clock = ~Clock;
  always @(posedge Clock) cyc <= cyc + 1;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, got no finish, required finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [19:0] got, input logic [19:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s: got %h required %h", tag, got, exp);
    end
  endtask

  // scoreboard monitors: each cycle either a result is due or DataValid must be low
  always @(negedge Clock) begin
    if (due1_q.size() > 0 && due1_q[0] == cyc) begin
      check("l1_valid", {19'd0, dv1}, 20'h1);
      check("l1_data", din1, exp1_q.pop_front());
      void'(due1_q.pop_front());
    end else check("l1_idle_valid", {19'd0, dv1}, 20'h0);
  end

  always @(negedge Clock) begin
    if (due2_q.size() > 0 && due2_q[0] == cyc) begin
      check("l2_valid", {19'd0, dv2}, 20'h1);
      check("l2_data", din2, exp2_q.pop_front());
      void'(due2_q.pop_front());
    end else check("l2_idle_valid", {19'd0, dv2}, 20'h0);
  end

  always @(negedge Clock) begin
    if (due4_q.size() > 0 && due4_q[0] == cyc) begin
      check("l4_valid", {19'd0, dv4}, 20'h1);
      check("l4_data", din4, exp4_q.pop_front());
      void'(due4_q.pop_front());
    end else check("l4_idle_valid", {19'd0, dv4}, 20'h0);
  end

  // driver: one cycle of inputs, model update, scoreboard push
  task automatic step(input logic w, input logic [19:0] addr, input logic [19:0] dout,
                      input logic le, input logic [3:0] la, input logic [19:0] ld);
    logic [19:0] rv;
    check("ready_l1", {19'd0, rdy1}, {19'd0, model_active});
    check("ready_l2", {19'd0, rdy2}, {19'd0, model_active});
    check("ready_l4", {19'd0, rdy4}, {19'd0, model_active});
    W = w; Daddress = addr; Dout = dout; LoadEn = le; LoadAddr = la; LoadData = ld;
    if (model_active) begin
      if (!w) begin
        rv = model_mem[addr[3:0]];
        exp1_q.push_back(rv); due1_q.push_back(cyc + 1);
        exp2_q.push_back(rv); due2_q.push_back(cyc + 2);
        exp4_q.push_back(rv); due4_q.push_back(cyc + 4);
      end
      if (le) model_mem[la] = ld;
      else if (w) model_mem[addr[3:0]] = dout;
    end
    @(posedge Clock); #1;
    if (!model_active) begin
      init_cnt++;
      if (init_cnt == 16) model_active = 1'b1;
    end
  endtask

  task automatic rd(input logic [19:0] addr);
    step(1'b0, addr, 20'h0, 1'b0, 4'h0, 20'h0);
  endtask

  task automatic do_reset();
    Reset = 1'b0; W = 1'b0; LoadEn = 1'b0; Daddress = '0;
    #2;
    check("rst_dv_l1", {19'd0, dv1}, 20'h0);
    check("rst_dv_l2", {19'd0, dv2}, 20'h0);
    check("rst_dv_l4", {19'd0, dv4}, 20'h0);
    check("rst_din_l2", din2, 20'h0);
    check("rst_din_l4", din4, 20'h0);
    check("rst_ready_l2", {19'd0, rdy2}, 20'h0);
    exp1_q.delete(); due1_q.delete();
    exp2_q.delete(); due2_q.delete();
    exp4_q.delete(); due4_q.delete();
    for (int i = 0; i < 16; i++) model_mem[i] = 20'h0;
    model_active = 1'b0;
    init_cnt = 0;
    #1 Reset = 1'b1;
  endtask

  initial begin
    logic [19:0] ra, rdat, rld;
    logic [3:0]  rla;
    logic        rw, rle;

    @(posedge Clock); #1;
    do_reset();

    // 1: INIT pass (Ready checked low each step), then read of address 0
    for (int i = 0; i < 16; i++) rd(20'h0);
    rd(20'h0);
    rd(20'h0);

    // 2: preload then back-to-back reads
    step(1'b1, 20'h0000F, 20'h0, 1'b1, 4'd3, 20'hC0F00);
    step(1'b1, 20'h0000F, 20'h0, 1'b1, 4'd4, 20'h01F00);
    rd(20'h3);
    rd(20'h4);

    // 3: aliased core write, read-first against a same-cycle preload
    step(1'b1, 20'h00015, 20'hABCDE, 1'b0, 4'd0, 20'h0);
    rd(20'h5);
    step(1'b0, 20'h5, 20'h0, 1'b1, 4'd5, 20'h11111);
    rd(20'h5);

    // 4: preload and core write in the same cycle
    step(1'b1, 20'h8, 20'h33333, 1'b1, 4'd7, 20'h22222);
    rd(20'h7);
    rd(20'h8);

    // 5: single read followed only by writes; DataIn must hold
    rd(20'h3);
    for (int i = 0; i < 6; i++)
      step(1'b1, 20'h9, 20'($urandom_range(0, 20'hFFFFF)), 1'b0, 4'd0, 20'h0);
    check("hold_l1", din1, 20'hC0F00);
    check("hold_l2", din2, 20'hC0F00);
    check("hold_l4", din4, 20'hC0F00);

    // mixed random traffic with full-width aliasing addresses
    for (int i = 0; i < 60; i++) begin
      rw   = 1'($urandom_range(0, 1));
      ra   = 20'($urandom_range(0, 20'hFFFFF));
      rdat = 20'($urandom_range(0, 20'hFFFFF));
      rle  = ($urandom_range(0, 3) == 0);
      rla  = 4'($urandom_range(0, 15));
      rld  = 20'($urandom_range(0, 20'hFFFFF));
      step(rw, ra, rdat, rle, rla, rld);
    end

    // 6: reset pulsed one cycle after a read
    rd(20'h3);
    do_reset();
    for (int i = 0; i < 16; i++) rd(20'h3);
    rd(20'h3);
    rd(20'h4);

    // drain with writes only, then the expected queues must be empty
    for (int i = 0; i < 6; i++) step(1'b1, 20'hF, 20'h0, 1'b0, 4'd0, 20'h0);
    check("drain_l1", 20'(exp1_q.size()), 20'h0);
    check("drain_l2", 20'(exp2_q.size()), 20'h0);
    check("drain_l4", 20'(exp4_q.size()), 20'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
